// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 host command sequencer.
//   - PS/2 command and response byte codes
//   - sequencer state enumeration and command-phase tracking type
//   - width of the response/self-test timeout counter
package ps2_pkg;

    // Host-to-keyboard commands
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;

    // Keyboard-to-host responses
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] RSP_ERR     = 8'hFC;

    localparam int unsigned TO_WIDTH = 27;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitTx,
        StWaitAck,
        StWaitBat,
        StDone,
        StErr
    } state_e;

    // Which byte of the current command is in flight; decides what an ACK means.
    typedef enum logic [1:0] {
        PhReset,
        PhLed,
        PhArg
    } phase_e;

endpackage

// File: rtl/ps2_timeout.sv
// ps2_timeout: saturating cycle counter with a programmable expiry limit.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clear   - synchronous clear (takes priority over enable)
//   enable  - count one cycle
//   limit   - expiry threshold
//   expired - high while enabled and the count has reached limit
module ps2_timeout
    import ps2_pkg::*;
#(
    parameter int unsigned WIDTH = TO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = enable && (count_q >= limit);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: host-side PS/2 keyboard command sequencer.
// Issues reset (FF, then waits for the BAT result) and Set-LEDs (ED + argument)
// commands with ACK/resend/timeout retry handling, and forwards scan bytes
// received while idle.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   init_req            - request keyboard reset
//   led_req, led_val    - request Set-LEDs with {caps, num, scroll}
//   rx_valid/byte/err   - byte from the PS/2 receiver
//   tx_start, tx_byte   - byte to the PS/2 transmitter
//   tx_done             - transmitter finished
//   busy, cmd_accept, cmd_done, cmd_error - command status
//   kb_ready            - keyboard passed self-test
//   key_valid, key_byte - forwarded scan byte
module ps2_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned BAT_CYC     = 100000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_err,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       busy,
    output logic       cmd_accept,
    output logic       cmd_done,
    output logic       cmd_error,
    output logic       kb_ready,
    output logic       key_valid,
    output logic [7:0] key_byte
);

    import ps2_pkg::*;

    localparam int unsigned AW = $clog2(MAX_RETRY + 1);
    localparam logic [TO_WIDTH-1:0] ACK_LIMIT = TO_WIDTH'(TIMEOUT_CYC - 1);
    localparam logic [TO_WIDTH-1:0] BAT_LIMIT = TO_WIDTH'(BAT_CYC - 1);

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [7:0]      arg_q, arg_d;
    logic [AW-1:0]   attempt_q, attempt_d;
    logic            kb_ready_q, kb_ready_d;
    logic            key_valid_q;
    logic [7:0]      key_byte_q;
    logic            accept;
    logic            expired;
    logic            rx_ok, rx_bad;

    assign rx_ok  = rx_valid & ~rx_err;
    assign rx_bad = rx_valid & rx_err;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tx_byte_d  = tx_byte_q;
        arg_d      = arg_q;
        attempt_d  = attempt_q;
        kb_ready_d = kb_ready_q;
        accept     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (init_req) begin
                    accept     = 1'b1;
                    tx_byte_d  = CMD_RESET;
                    phase_d    = PhReset;
                    attempt_d  = '0;
                    kb_ready_d = 1'b0;
                    state_d    = StSend;
                end else if (led_req) begin
                    accept    = 1'b1;
                    tx_byte_d = CMD_SET_LED;
                    arg_d     = {5'b0, led_val};
                    phase_d   = PhLed;
                    attempt_d = '0;
                    state_d   = StSend;
                end else if (rx_ok && (rx_byte == RSP_BAT_OK)) begin
                    // Hot-plugged keyboard announcing a completed self-test.
                    kb_ready_d = 1'b1;
                end
            end
            StSend: state_d = StWaitTx;
            StWaitTx: begin
                if (tx_done) state_d = StWaitAck;
            end
            StWaitAck: begin
                if (rx_ok && (rx_byte == RSP_ACK)) begin
                    case (phase_q)
                        PhReset: state_d = StWaitBat;
                        PhLed: begin
                            tx_byte_d = arg_q;
                            phase_d   = PhArg;
                            attempt_d = '0;
                            state_d   = StSend;
                        end
                        default: state_d = StDone;
                    endcase
                end else if ((rx_ok && ((rx_byte == RSP_RESEND) || (rx_byte == RSP_ERR)))
                             || rx_bad || expired) begin
                    // The failed attempt counts; give up once MAX_RETRY are spent.
                    if (32'(attempt_q) + 32'd1 >= MAX_RETRY) begin
                        state_d = StErr;
                    end else begin
                        attempt_d = attempt_q + 1'b1;
                        state_d   = StSend;
                    end
                end
            end
            StWaitBat: begin
                if (rx_ok && (rx_byte == RSP_BAT_OK)) begin
                    kb_ready_d = 1'b1;
                    state_d    = StDone;
                end else if ((rx_ok && (rx_byte == RSP_ERR)) || rx_bad || expired) begin
                    kb_ready_d = 1'b0;
                    state_d    = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            phase_q     <= PhReset;
            tx_byte_q   <= 8'h00;
            arg_q       <= 8'h00;
            attempt_q   <= '0;
            kb_ready_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_byte_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tx_byte_q   <= tx_byte_d;
            arg_q       <= arg_d;
            attempt_q   <= attempt_d;
            kb_ready_q  <= kb_ready_d;
            key_valid_q <= (state_q == StIdle) && rx_ok;
            if ((state_q == StIdle) && rx_ok) key_byte_q <= rx_byte;
        end
    end

    // Clearing on any state change restarts the timeout per wait state.
    ps2_timeout #(
        .WIDTH (TO_WIDTH)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (state_d != state_q),
        .enable  ((state_q == StWaitAck) || (state_q == StWaitBat)),
        .limit   ((state_q == StWaitBat) ? BAT_LIMIT : ACK_LIMIT),
        .expired (expired)
    );

    // Combinational strobes are masked by RST so reset wins within the same cycle.
    assign tx_start   = ~RST & (state_q == StSend);
    assign cmd_accept = ~RST & accept;
    assign cmd_done   = ~RST & (state_q == StDone);
    assign cmd_error  = ~RST & (state_q == StErr);
    assign busy       = ~RST & ((state_q != StIdle) | accept);
    assign tx_byte    = tx_byte_q;
    assign kb_ready   = kb_ready_q;
    assign key_valid  = key_valid_q;
    assign key_byte   = key_byte_q;

endmodule

// File: doc/ps2_cmd_sequencer.md
PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 2000000: response timeout in CLK cycles (20 ms at 100 MHz).
REQ-002 The block SHALL have parameter BAT_CYC, default 100000000: self-test (BAT) completion timeout in CLK cycles.
REQ-003 The block SHALL have parameter MAX_RETRY, default 3: transmit attempts per byte before error.
REQ-004 The block SHALL have the following ports; one clock, reset synchronous and active-high:
- CLK  in  1  board clock
- RST  in  1  synchronous active-high reset
- init_req  in  1  pulse: send reset (FF), wait BAT
- led_req  in  1  pulse: send Set-LEDs (ED + arg)
- led_val  in  3  {caps, num, scroll}, sampled when led_req is accepted
- rx_valid  in  1  1-cycle pulse: receiver has a byte
- rx_byte  in  8  received data byte
- rx_err  in  1  qualifies rx_valid: frame/parity error
- tx_start  out  1  1-cycle pulse to transmitter
- tx_byte  out  8  byte to send, held stable while the transmitter is busy
- tx_done  in  1  1-cycle pulse: transmitter finished the frame
- busy  out  1  high from the accept cycle until DONE/ERR
- cmd_accept  out  1  1-cycle pulse: request accepted
- cmd_done  out  1  1-cycle pulse: command completed OK
- cmd_error  out  1  1-cycle pulse: retries or timeout exhausted
- kb_ready  out  1  level: keyboard passed BAT
- key_valid  out  1  1-cycle pulse: scan byte forwarded
- key_byte  out  8  forwarded scan byte

Function
REQ-005 The FSM SHALL have the states IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, DONE, ERR; DONE and ERR SHALL each last 1 cycle, then return to IDLE.
REQ-006 In IDLE, init_req SHALL be accepted: cmd_accept is pulsed, tx_byte=FF, the attempt count is cleared, next state SEND.
REQ-007 In IDLE, led_req SHALL be accepted when init_req is low: tx_byte=ED, the argument {5'b0,led_val} is latched, next state SEND.
REQ-008 If init_req and led_req are asserted in the same cycle, init_req SHALL win and led_req SHALL be dropped; requests outside IDLE SHALL be ignored with no accept pulse.
REQ-009 SEND SHALL pulse tx_start for one cycle and go to WAIT_TX; WAIT_TX SHALL go to WAIT_ACK on tx_done and clear the timeout counter.
REQ-010 In WAIT_ACK, a valid FA SHALL mean: after FF go to WAIT_BAT; after ED load the argument into tx_byte, reset the attempt count and go to SEND; after the argument go to DONE.
REQ-011 In WAIT_ACK, a valid FE, a valid FC, rx_err, or a timeout (counter reaching TIMEOUT_CYC-1) SHALL increment the attempt count and resend the same tx_byte (go to SEND); when the count reaches MAX_RETRY the FSM SHALL go to ERR instead.
REQ-012 In WAIT_BAT, a valid AA SHALL set kb_ready and go to DONE; a valid FC, rx_err, or a BAT_CYC timeout SHALL clear kb_ready and go to ERR.
REQ-013 kb_ready SHALL clear on accept of init_req.
REQ-014 A valid AA received in IDLE (hot-plug) SHALL set kb_ready and SHALL also be forwarded as a key byte.
REQ-015 A valid rx byte in IDLE SHALL be forwarded on key_byte with key_valid one cycle later; bytes received outside IDLE SHALL be consumed and not forwarded; rx_err bytes SHALL never be forwarded.
REQ-016 The timeout counter SHALL be 27 bits, SHALL saturate and not wrap, and SHALL clear on every state change.
REQ-017 cmd_done SHALL pulse in DONE and cmd_error SHALL pulse in ERR; busy SHALL be low in IDLE only.

Reset
REQ-018 On RST, the FSM SHALL go to IDLE and all pulses, busy, kb_ready and counters SHALL be 0; tx_byte and key_byte SHALL be 00.
REQ-019 RST mid-command SHALL abort the command with no cmd_done and no cmd_error; RST SHALL override every input in the same cycle.

Structure
REQ-020 Package ps2_pkg SHALL hold the byte constants (CMD_RESET FF, CMD_SET_LED ED, RSP_ACK FA, RSP_RESEND FE, RSP_BAT_OK AA, RSP_ERR FC) and the state enumeration.
REQ-021 The timeout counter SHALL be a sub-module ps2_timeout (clear, enable, limit, expired).

Verification
REQ-022 init_req; after tx_done respond FA then AA -> exactly 1 tx_start (FF), cmd_done, kb_ready=1.
REQ-023 led_req with led_val=3'b101; respond FA, then FA -> tx bytes ED then 05, cmd_done, no key_valid.
REQ-024 led_req; respond FE, FE, FA, FA -> ED sent 3 times, then 05 once, cmd_done.
REQ-025 init_req with no response, TIMEOUT_CYC reduced to 100 -> 3 FF transmissions spaced by the timeout, then cmd_error, kb_ready=0.
REQ-026 IDLE rx bytes 1C, F0, 1C -> 3 key_valid pulses with those values; an rx byte with rx_err -> no pulse.
REQ-027 RST asserted in WAIT_ACK -> IDLE next cycle, busy=0, no cmd_done/cmd_error.
